// File: rtl/sseg_pkg.sv
// Shared definitions for seven-segment capture: segment patterns (active-low {a..g}),
// capture FSM states, and a pattern-to-nibble helper.
package sseg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } sseg_state_e;

   // Returns {valid, nibble}; valid is low for any pattern outside the hex glyph set.
   function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         SEG_0:   r = {1'b1, 4'h0};
         SEG_1:   r = {1'b1, 4'h1};
         SEG_2:   r = {1'b1, 4'h2};
         SEG_3:   r = {1'b1, 4'h3};
         SEG_4:   r = {1'b1, 4'h4};
         SEG_5:   r = {1'b1, 4'h5};
         SEG_6:   r = {1'b1, 4'h6};
         SEG_7:   r = {1'b1, 4'h7};
         SEG_8:   r = {1'b1, 4'h8};
         SEG_9:   r = {1'b1, 4'h9};
         SEG_A:   r = {1'b1, 4'hA};
         SEG_B:   r = {1'b1, 4'hB};
         SEG_C:   r = {1'b1, 4'hC};
         SEG_D:   r = {1'b1, 4'hD};
         SEG_E:   r = {1'b1, 4'hE};
         SEG_F:   r = {1'b1, 4'hF};
         default: r = 5'b0_0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational seven-segment pattern decoder: pattern -> {valid, blank, nibble}.
// SSEG_SCAN_CAPTURE_BLANK_EN makes the all-off pattern a recognised blank digit.
module sseg_pattern_decode
   import sseg_pkg::*;
(
   input  logic [6:0] seg,
   output logic       valid,
   output logic       blank,
   output logic [3:0] nibble
);

`ifdef SSEG_SCAN_CAPTURE_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   logic [4:0] dec;

   always_comb begin
      dec    = seg_to_nibble(seg);
      valid  = dec[4];
      nibble = dec[3:0];
      blank  = BLANK_EN && (seg == SEG_BLANK);
   end

endmodule

// File: rtl/sseg_scan_capture.sv
// Captures the nibble shown on each digit of a scanned common-anode display bus.
// Build option SSEG_SCAN_CAPTURE_BLANK_EN (in sseg_pattern_decode) accepts blank digits.
module sseg_scan_capture
   import sseg_pkg::*;
#(
   parameter int NDIG           = 4,
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [6:0]               sseg,
   input  logic [NDIG-1:0]          an,
   input  logic                     err_clr,
   output logic [4*NDIG-1:0]        digits,
   output logic [NDIG-1:0]          digit_valid,
   output logic                     digit_upd,
   output logic [$clog2(NDIG)-1:0]  upd_idx,
   output logic                     frame_done,
   output logic                     pat_err
);

   localparam int IW = $clog2(NDIG);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

   sseg_state_e       state_q, state_d;
   logic [NDIG-1:0]   s_an_q, p_an_q;
   logic [6:0]        s_seg_q, p_seg_q;
   logic [CW-1:0]     stable_cnt_q, stable_cnt_d;
   logic [TW-1:0]     idle_cnt_q, idle_cnt_d;
   logic [4*NDIG-1:0] digits_q, digits_d;
   logic [NDIG-1:0]   valid_q, valid_d, mask_q, mask_d;
   logic              upd_q, upd_d, frame_q, frame_d, pat_err_q, pat_err_d;
   logic [IW-1:0]     upd_idx_q, upd_idx_d;

   logic              changed, sel_ok, capture;
   logic [IW-1:0]     sel_idx;
   logic              dec_valid, dec_blank;
   logic [3:0]        dec_nibble;

   sseg_pattern_decode u_decode (
      .seg    (s_seg_q),
      .valid  (dec_valid),
      .blank  (dec_blank),
      .nibble (dec_nibble)
   );

   // stable_cnt tracks the run length of identical samples, including the current one.
   always_comb begin
      changed = (s_an_q != p_an_q) || (s_seg_q != p_seg_q);
      sel_ok  = $onehot(~s_an_q);
      sel_idx = '0;
      for (int k = 0; k < NDIG; k++) begin
         if (!s_an_q[k]) sel_idx = IW'(k);
      end
      if (changed)                         stable_cnt_d = CW'(1);
      else if (stable_cnt_q == STABLE_MAX) stable_cnt_d = STABLE_MAX;
      else                                 stable_cnt_d = stable_cnt_q + CW'(1);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WAIT:    if (sel_ok) state_d = (stable_cnt_d == STABLE_MAX) ? HOLD : COUNT;
         COUNT: begin
            if (changed || !sel_ok)             state_d = WAIT;
            else if (stable_cnt_d == STABLE_MAX) state_d = HOLD;
         end
         HOLD:    if (changed) state_d = WAIT;
         default: state_d = WAIT;
      endcase
   end

   always_comb begin
      capture = (state_q != HOLD) && sel_ok && !changed && (stable_cnt_d == STABLE_MAX);
   end

   // A completed frame mask is reported one cycle later and cleared at that moment.
   always_comb begin
      digits_d   = digits_q;
      valid_d    = valid_q;
      upd_d      = 1'b0;
      upd_idx_d  = upd_idx_q;
      frame_d    = &mask_q;
      mask_d     = (&mask_q) ? '0 : mask_q;
      pat_err_d  = pat_err_q & ~err_clr;
      idle_cnt_d = (idle_cnt_q == TIMEOUT_MAX) ? idle_cnt_q : idle_cnt_q + TW'(1);
      if (idle_cnt_q == TIMEOUT_MAX - TW'(1)) begin
         valid_d = '0;
         mask_d  = '0;
      end
      if (capture) begin
         if (dec_valid) begin
            digits_d[4*sel_idx +: 4] = dec_nibble;
            valid_d[sel_idx]         = 1'b1;
            mask_d[sel_idx]          = 1'b1;
            upd_d                    = 1'b1;
            upd_idx_d                = sel_idx;
            idle_cnt_d               = '0;
         end else if (dec_blank) begin
            valid_d[sel_idx] = 1'b0;
            mask_d[sel_idx]  = 1'b1;
         end else begin
            pat_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= WAIT;
         s_an_q       <= '1;
         p_an_q       <= '1;
         s_seg_q      <= '1;
         p_seg_q      <= '1;
         stable_cnt_q <= '0;
         idle_cnt_q   <= '0;
         digits_q     <= '0;
         valid_q      <= '0;
         mask_q       <= '0;
         upd_q        <= 1'b0;
         upd_idx_q    <= '0;
         frame_q      <= 1'b0;
         pat_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         s_an_q       <= an;
         p_an_q       <= s_an_q;
         s_seg_q      <= sseg;
         p_seg_q      <= s_seg_q;
         stable_cnt_q <= stable_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
         digits_q     <= digits_d;
         valid_q      <= valid_d;
         mask_q       <= mask_d;
         upd_q        <= upd_d;
         upd_idx_q    <= upd_idx_d;
         frame_q      <= frame_d;
         pat_err_q    <= pat_err_d;
      end
   end

   assign digits      = digits_q;
   assign digit_valid = valid_q;
   assign digit_upd   = upd_q;
   assign upd_idx     = upd_idx_q;
   assign frame_done  = frame_q;
   assign pat_err     = pat_err_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture (NDIG=4, STABLE_CYCLES=4, TIMEOUT_CYCLES=64).
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
module tb_sseg_scan_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  sseg = 7'h7f;
   logic [3:0]  an = 4'hf;
   logic        err_clr = 1'b0;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        digit_upd;
   logic [1:0]  upd_idx;
   logic        frame_done;
   logic        pat_err;

   int n_cmp = 0;
   int n_err = 0;
   int upd_cnt = 0;
   int frame_cnt = 0;

   always #5 clk = ~clk;

   sseg_scan_capture #(
      .NDIG           (4),
      .STABLE_CYCLES  (4),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sseg        (sseg),
      .an          (an),
      .err_clr     (err_clr),
      .digits      (digits),
      .digit_valid (digit_valid),
      .digit_upd   (digit_upd),
      .upd_idx     (upd_idx),
      .frame_done  (frame_done),
      .pat_err     (pat_err)
   );

   always @(negedge clk) begin
      if (digit_upd)  upd_cnt++;
      if (frame_done) frame_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      an   = a;
      sseg = s;
      step(n);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
   endtask

   initial begin
      step(3);
      check("rst_digits", 32'(digits), 32'h0);
      check("rst_valid", 32'(digit_valid), 32'h0);
      check("rst_upd", 32'(digit_upd), 32'h0);
      check("rst_idx", 32'(upd_idx), 32'h0);
      check("rst_frame", 32'(frame_done), 32'h0);
      check("rst_pat_err", 32'(pat_err), 32'h0);
      rst = 1'b0;

      // Full scan 2,3,4,5
      hold(4'b1110, 7'b0010010, 8);
      hold(4'b1101, 7'b0000110, 8);
      hold(4'b1011, 7'b1001100, 8);
      check("scan_no_frame_yet", 32'(frame_cnt), 32'd0);
      hold(4'b0111, 7'b0100100, 8);
      check("scan_digits", 32'(digits), 32'h5432);
      check("scan_upd_cnt", 32'(upd_cnt), 32'd4);
      check("scan_frame_cnt", 32'(frame_cnt), 32'd1);
      check("scan_valid", 32'(digit_valid), 32'hf);

      // Exact latency: four samples, capture on the edge the next value arrives
      hold(4'b1101, 7'b0001000, 4);
      check("lat_no_early", 32'(digit_upd), 32'h0);
      an = 4'b1111;
      step(1);
      check("lat_upd", 32'(digit_upd), 32'h1);
      check("lat_idx", 32'(upd_idx), 32'h1);
      check("lat_digit1", 32'(digits[7:4]), 32'hA);
      step(1);
      check("lat_one_pulse", 32'(digit_upd), 32'h0);

      // Only three stable samples: no capture
      hold(4'b1111, 7'b0000110, 2);
      hold(4'b1110, 7'b0000110, 3);
      hold(4'b1111, 7'b0000110, 10);
      check("short_no_upd", 32'(upd_cnt), 32'd5);
      check("short_digits", 32'(digits), 32'h54A2);

      // Undecodable pattern, clear, and set-beats-clear
      hold(4'b1110, 7'b1010101, 8);
      check("bad_pat_err", 32'(pat_err), 32'h1);
      check("bad_digits", 32'(digits), 32'h54A2);
      check("bad_no_upd", 32'(upd_cnt), 32'd5);
      pulse_clr();
      check("err_clr", 32'(pat_err), 32'h0);
      hold(4'b1111, 7'b1010101, 2);
      hold(4'b1110, 7'b1010101, 4);
      check("err_pre_set", 32'(pat_err), 32'h0);
      pulse_clr();
      check("err_set_wins", 32'(pat_err), 32'h1);
      pulse_clr();
      check("err_clr2", 32'(pat_err), 32'h0);

      // Two anodes low, then none low
      hold(4'b1100, 7'b0000000, 20);
      hold(4'b1111, 7'b0000000, 20);
      check("multi_no_upd", 32'(upd_cnt), 32'd5);
      check("multi_no_err", 32'(pat_err), 32'h0);

      // Frame 1,7,8,9 then idle timeout at exactly 64 cycles after last capture
      hold(4'b1110, 7'b1001111, 8);
      hold(4'b1101, 7'b0001111, 8);
      hold(4'b1011, 7'b0000000, 8);
      hold(4'b0111, 7'b0000100, 8);
      check("to_frame_cnt", 32'(frame_cnt), 32'd2);
      check("to_digits", 32'(digits), 32'h9871);
      check("to_valid_full", 32'(digit_valid), 32'hf);
      hold(4'b1111, 7'b0000100, 60);
      check("to_before", 32'(digit_valid), 32'hf);
      step(1);
      check("to_expired", 32'(digit_valid), 32'h0);
      check("to_digits_kept", 32'(digits), 32'h9871);
      hold(4'b1011, 7'b0100000, 8);
      check("to_recapture_valid", 32'(digit_valid), 32'h4);
      check("to_recapture_digits", 32'(digits), 32'h9671);
      hold(4'b1111, 7'b0100000, 60);
      check("to_restart_before", 32'(digit_valid), 32'h4);
      step(1);
      check("to_restart_expired", 32'(digit_valid), 32'h0);

      // Reset while counting (count 3): pending capture is dropped
      hold(4'b1101, 7'b1010101, 8);
      check("pre_rst_err", 32'(pat_err), 32'h1);
      hold(4'b1111, 7'b0000001, 2);
      hold(4'b1110, 7'b0000001, 4);
      rst = 1'b1;
      an  = 4'b1111;
      step(1);
      check("midrst_digits", 32'(digits), 32'h0);
      check("midrst_valid", 32'(digit_valid), 32'h0);
      check("midrst_upd", 32'(digit_upd), 32'h0);
      check("midrst_idx", 32'(upd_idx), 32'h0);
      check("midrst_frame", 32'(frame_done), 32'h0);
      check("midrst_pat_err", 32'(pat_err), 32'h0);
      rst = 1'b0;
      step(10);
      check("midrst_no_capture", 32'(upd_cnt), 32'd10);

      // Digit 2 shows the all-off pattern
      hold(4'b1110, 7'b1001111, 8);
      hold(4'b1101, 7'b0010010, 8);
      hold(4'b1011, 7'b1111111, 8);
      hold(4'b0111, 7'b0000110, 8);
      check("blank_valid", 32'(digit_valid), 32'hb);
      check("blank_digits", 32'(digits), 32'h3021);
      check("blank_upd_cnt", 32'(upd_cnt), 32'd13);
`ifdef SSEG_SCAN_CAPTURE_BLANK_EN
      check("blank_no_err", 32'(pat_err), 32'h0);
      check("blank_frame", 32'(frame_cnt), 32'd3);
`else
      check("blank_is_err", 32'(pat_err), 32'h1);
      check("blank_no_frame", 32'(frame_cnt), 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sseg_scan_capture.md
Name: sseg_scan_capture

Overview:
- Reverse-direction partner of the BCD-to-seven-segment decoder: observes a time-multiplexed, common-anode seven-segment bus (segment lines plus active-low anode enables).
- Recovers the hex nibble shown on each digit.
- Used for loopback self-check of the display path and for on-board capture of scanned display data.
- Sits between the display-driver outputs (tapped) and a status/register block.

Parameters:
- NDIG, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 4, consecutive identical samples of (an, sseg) required before a capture (>=2).
- TIMEOUT_CYCLES, 1000000, cycles without any capture before all digits are marked stale (>=16).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sseg  in  7  segment lines {a,b,c,d,e,f,g}, active-low (0 = lit, common anode).
- an  in  NDIG  anode enables, active-low; a valid select is exactly one bit low.
- err_clr  in  1  one-cycle pulse; clears pat_err.
- digits  out  4*NDIG  captured nibbles; digit k is digits[4k+3:4k].
- digit_valid  out  NDIG  bit k is high while digit k holds a fresh capture.
- digit_upd  out  1  one-cycle pulse on each successful capture.
- upd_idx  out  $clog2(NDIG)  index of the digit written on the digit_upd cycle.
- frame_done  out  1  one-cycle pulse when all digits have been captured since the previous frame_done.
- pat_err  out  1  sticky flag: a stable, valid-anode pattern did not decode.

Behaviour:
- Reset: digits=0, digit_valid=0, digit_upd=0, upd_idx=0, frame_done=0, pat_err=0, FSM=WAIT, counters=0, frame mask=0.
- Input stage: an and sseg are registered once (s_an, s_seg) and compared with the previous sample each cycle.
- FSM states:
  - WAIT: idle. Go to COUNT when s_an is one-hot-low; otherwise stay.
  - COUNT: stable_cnt increments while the sample is unchanged. Any change of the sample or loss of one-hot-low returns to WAIT with the count reset. When the count reaches STABLE_CYCLES: decode, write, go to HOLD.
  - HOLD: no re-capture. Return to WAIT on any sample change.
- Decode table (sseg -> nibble): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->b, 0110001->C, 1000010->d, 0110000->E, 0111000->F. Every other pattern is invalid.
- Valid capture:
  - digits[k] <= nibble; digit_valid[k] <= 1; digit_upd pulses with upd_idx=k; frame-mask bit k is set.
  - Latency: a new (an, sseg) value at the ports at edge t gives digit_upd high after edge t+STABLE_CYCLES+1.
- Invalid capture: pat_err is set; digits and digit_valid are unchanged; no digit_upd.
- Simultaneous err_clr and a new error: the set wins.
- frame_done pulses the cycle after the capture that completes the frame mask. The mask clears in the same cycle. Recapturing an already-captured digit before the frame completes does not reset the mask.
- Timeout:
  - idle_cnt counts cycles since the last valid capture.
  - On reaching TIMEOUT_CYCLES: digit_valid=0 and the frame mask clears; digits are retained.
  - idle_cnt saturates until the next capture.
- Multiple anodes low or none low: treated as "no digit selected"; never captured, never flagged as pat_err.
- Reset asserted mid-COUNT: any pending capture is discarded; all outputs return to reset values the next cycle.

Optional Feature:
- Macro SSEG_SCAN_CAPTURE_BLANK_EN.
- Defined: pattern 1111111 (all segments off) is legal "blank". It clears digit_valid[k], writes nothing to digits, raises no pat_err and no digit_upd, and still sets frame-mask bit k, so partially blanked displays complete frames.
- Undefined: 1111111 is an invalid pattern and sets pat_err.

Decomposition:
- Package sseg_pkg: 7-bit segment pattern constants for 0-F, the BLANK pattern, the FSM state enum (WAIT, COUNT, HOLD), and a function seg_to_nibble returning {valid, nibble}.
- One sub-module: sseg_pattern_decode, combinational pattern -> {valid, blank, nibble}. Shareable with future display self-test blocks.

Test Plan (NDIG=4, STABLE_CYCLES=4, TIMEOUT_CYCLES=64):
- Scan an=1110/0010010, 1101/0000110, 1011/1001100, 0111/0100100, 8 cycles each -> digits=0x5432, digit_upd four times, frame_done once after the fourth capture.
- an=1101, sseg=0001000, held exactly 4 cycles then changed -> capture at edge 5 with upd_idx=1, digit 1=0xA. Held only 3 cycles -> no digit_upd.
- Stable an=1110 with sseg=1010101 -> pat_err=1, digits unchanged. err_clr pulse -> pat_err=0. err_clr coincident with a new error -> pat_err stays 1.
- an=1100 or an=1111 held 20 cycles with a valid pattern -> no digit_upd, no pat_err.
- One full frame, then 64 idle cycles -> digit_valid=0000 and digits retained. Next valid capture -> bit set, idle counter restarts.
- rst asserted during COUNT at count 3 -> no capture; all outputs 0 next cycle. With SSEG_SCAN_CAPTURE_BLANK_EN defined, sseg=1111111 on digit 2 -> digit_valid[2]=0, no pat_err, frame still completes.
